cache_control: RTL and testbench
================================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have no parameters; geometry is fixed at 2 ways and 8 sets of 256-bit lines; way vector bit0 = left, bit1 = right.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 mem_read  in  1  CPU read request, held until mem_resp.
REQ-005 mem_write  in  1  CPU write request, held until mem_resp.
REQ-006 mem_resp  out  1  one-cycle access-complete pulse to CPU.
REQ-007 pmem_read  out  1  line-fill request, held until pmem_resp.
REQ-008 pmem_write  out  1  line-writeback request, held until pmem_resp.
REQ-009 pmem_resp  in  1  physical memory completion pulse.
REQ-010 hit  in  2  per-way valid-and-tag-match from datapath.
REQ-011 dirty  in  2  per-way dirty bit at current index.
REQ-012 lru  in  1  victim way at current index (0 left, 1 right).
REQ-013 tag_write  out  2  per-way tag array write enable.
REQ-014 data_write  out  2  per-way data array write enable.
REQ-015 valid_write  out  2  per-way valid array write enable.
REQ-016 dirty_write  out  2  per-way dirty array write enable (datapath writes mem_write).
REQ-017 lru_write  out  1  LRU array write enable (datapath writes hit[0]).
REQ-018 writebackmux_sel  out  1  data array source: 0 pmem_rdata, 1 modified CPU word.
REQ-019 address_to_pmem_sel  out  2  pmem address: 0 CPU address, 1 left tag line, 2 right tag line.

Function
REQ-020 SHALL implement states IDLE, WRITEBACK, FILL; all outputs are decoded combinationally from state and inputs; every output not named in a state is 0.
REQ-021 IDLE, request with |hit: mem_resp=1 and lru_write=1 in the same cycle (hit latency 0 cycles after request sampled); remain IDLE.
REQ-022 IDLE write hit: additionally data_write=hit, dirty_write=hit, writebackmux_sel=1.
REQ-023 IDLE read hit: no data, tag, valid or dirty write.
REQ-024 IDLE miss with dirty[lru]=1 -> WRITEBACK; miss with dirty[lru]=0 -> FILL; no mem_resp and no array write on miss.
REQ-025 WRITEBACK: pmem_write=1, address_to_pmem_sel=1+lru; on pmem_resp -> FILL.
REQ-026 FILL: pmem_read=1, address_to_pmem_sel=0, writebackmux_sel=0; on pmem_resp assert tag_write, data_write, valid_write, dirty_write on way lru only, then -> IDLE.
REQ-027 After FILL, IDLE re-evaluates the still-held request, which hits; miss latency = pmem fill time(s) + 1 cycle.
REQ-028 mem_read and mem_write both high SHALL be treated as write.
REQ-029 Requester contract: request deasserted or changed the cycle after mem_resp; a held request is served again.
REQ-030 pmem_read and pmem_write SHALL never be asserted together; pmem_resp outside WRITEBACK/FILL is ignored.
REQ-031 Request dropped mid-miss SHALL NOT abort the miss; FILL completes, then IDLE idles.

Reset
REQ-032 rst high at an edge SHALL force IDLE; all outputs 0 in the following cycle, including mid-WRITEBACK/FILL (pmem request withdrawn).
REQ-033 Controller SHALL NOT clear datapath arrays; valid array initialization is the arrays' responsibility.

Structure
REQ-034 State enum and address_to_pmem_sel encodings (ADDR_CPU, ADDR_WB_LEFT, ADDR_WB_RIGHT) SHALL live in rv32i_types.
REQ-035 Single module with one state register; no sub-module.

Verification
REQ-036 Read hit: hit=01, mem_read=1 -> same cycle mem_resp=1, lru_write=1, data_write=00.
REQ-037 Write hit right: hit=10, mem_write=1 -> mem_resp=1, data_write=10, dirty_write=10, writebackmux_sel=1.
REQ-038 Clean miss: hit=00, lru=1, dirty=00, pmem_resp after 5 cycles -> pmem_read 5 cycles, addr_sel=0, on resp tag/data/valid/dirty_write=10, mem_resp next cycle after hit=10.
REQ-039 Dirty miss: lru=0, dirty=01 -> pmem_write with addr_sel=1 until pmem_resp, then pmem_read, fill way 01.
REQ-040 rst asserted in FILL cycle 3 -> next cycle pmem_read=0, state IDLE, all outputs 0.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: cache controller state encoding and pmem address-select encodings
package rv32i_types;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;
  typedef enum logic [1:0] {
    ADDR_CPU      = 2'd0,
    ADDR_WB_LEFT  = 2'd1,
    ADDR_WB_RIGHT = 2'd2
  } addr_sel_e;
endpackage

// File: rtl/cache_control.sv
// cache_control: 2-way write-back cache FSM; CPU req/resp, pmem req/resp, datapath hit/dirty/lru in, array write enables and mux selects out
module cache_control
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  input  logic [1:0] hit,
  input  logic [1:0] dirty,
  input  logic       lru,
  output logic [1:0] tag_write,
  output logic [1:0] data_write,
  output logic [1:0] valid_write,
  output logic [1:0] dirty_write,
  output logic       lru_write,
  output logic       writebackmux_sel,
  output logic [1:0] address_to_pmem_sel
);
  state_e state_q, state_d;
  logic req;
  logic [1:0] way;
  assign req = mem_read | mem_write;
  assign way = lru ? 2'b10 : 2'b01;
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    tag_write = 2'b00;
    data_write = 2'b00;
    valid_write = 2'b00;
    dirty_write = 2'b00;
    lru_write = 1'b0;
    writebackmux_sel = 1'b0;
    address_to_pmem_sel = ADDR_CPU;
    case (state_q)
      IDLE: begin
        if (req && |hit) begin
          mem_resp = 1'b1;
          lru_write = 1'b1;
          data_write = mem_write ? hit : 2'b00;
          dirty_write = mem_write ? hit : 2'b00;
          writebackmux_sel = mem_write;
        end else if (req) begin
          state_d = dirty[lru] ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        address_to_pmem_sel = lru ? ADDR_WB_RIGHT : ADDR_WB_LEFT;
        state_d = pmem_resp ? FILL : WRITEBACK;
      end
      FILL: begin
        pmem_read = 1'b1;
        tag_write = pmem_resp ? way : 2'b00;
        data_write = pmem_resp ? way : 2'b00;
        valid_write = pmem_resp ? way : 2'b00;
        dirty_write = pmem_resp ? way : 2'b00;
        state_d = pmem_resp ? IDLE : FILL;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: vector table, directed miss/reset sequences and random traffic against an abstract LRU cache model
module tb_cache_control;
  logic clk = 1'b0, rst, mem_read, mem_write, pmem_resp, lru;
  logic mem_resp, pmem_read, pmem_write, lru_write, writebackmux_sel;
  logic [1:0] hit, dirty, tag_write, data_write, valid_write, dirty_write, address_to_pmem_sel;
  logic [14:0] outs;
  int vectors = 0, miscompares = 0;

  cache_control dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp), .hit(hit),
    .dirty(dirty), .lru(lru), .tag_write(tag_write), .data_write(data_write),
    .valid_write(valid_write), .dirty_write(dirty_write), .lru_write(lru_write),
    .writebackmux_sel(writebackmux_sel), .address_to_pmem_sel(address_to_pmem_sel)
  );

  always #5 clk = ~clk;

  assign outs = {mem_resp, pmem_read, pmem_write, tag_write, data_write, valid_write,
                 dirty_write, lru_write, writebackmux_sel, address_to_pmem_sel};

  typedef struct {
    logic rd, wr;
    logic [1:0] h, d;
    logic l, pr;
    logic [14:0] exp;
  } vec_t;
  vec_t tbl[7];

  localparam logic [14:0] HIT_RD  = 15'b1_0_0_00_00_00_00_1_0_00;
  localparam logic [14:0] FILL_O  = 15'b0_1_0_00_00_00_00_0_0_00;
  localparam logic [14:0] WB_L    = 15'b0_0_1_00_00_00_00_0_0_01;

  logic [1:0] dtag[8][2];
  logic dvalid[8][2], ddirty[8][2], dlru[8];
  int mtag[8][2], mcnt[8];
  logic mdirty[8][2];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, wr, input logic [1:0] h, d, input logic l, pr);
    mem_read = rd; mem_write = wr; hit = h; dirty = d; lru = l; pmem_resp = pr;
  endtask

  task automatic cyc(input string nm, input logic [14:0] exp);
    #1 chk(nm, int'(outs), int'(exp));
    @(negedge clk);
  endtask

  initial begin
    int s, t, w, pos, vw, c, lat, wbc, fc, pc, plat, badsel, both;
    logic exp_hit, exp_wb, done;
    tbl[0] = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 15'b0};
    tbl[1] = '{1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, HIT_RD};
    tbl[2] = '{1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 15'b1_0_0_00_10_00_10_1_1_00};
    tbl[3] = '{1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 15'b1_0_0_00_01_00_01_1_1_00};
    tbl[4] = '{1'b0, 1'b1, 2'b01, 2'b11, 1'b1, 1'b0, 15'b1_0_0_00_01_00_01_1_1_00};
    tbl[5] = '{1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, HIT_RD};
    tbl[6] = '{1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 1'b1, 15'b0};
    rst = 1'b1;
    drive(0, 0, 2'b00, 2'b00, 0, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cyc("reset_state", 15'b0);
    foreach (tbl[i]) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].h, tbl[i].d, tbl[i].l, tbl[i].pr);
      cyc($sformatf("table_%0d", i), tbl[i].exp);
    end
    drive(1, 0, 2'b00, 2'b00, 1, 0);
    cyc("clean_idle", 15'b0);
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 2'b00, 2'b00, 1, i == 5);
      cyc($sformatf("clean_fill_%0d", i), i == 5 ? 15'b0_1_0_10_10_10_10_0_0_00 : FILL_O);
    end
    drive(1, 0, 2'b10, 2'b00, 1, 0);
    cyc("clean_hit", HIT_RD);
    drive(0, 0, 2'b10, 2'b00, 1, 0);
    cyc("clean_after", 15'b0);
    drive(1, 0, 2'b00, 2'b01, 0, 0);
    cyc("dirty_idle", 15'b0);
    for (int i = 1; i <= 2; i++) begin
      drive(1, 0, 2'b00, 2'b01, 0, i == 2);
      cyc($sformatf("dirty_wb_%0d", i), WB_L);
    end
    for (int i = 1; i <= 2; i++) begin
      drive(1, 0, 2'b00, 2'b01, 0, i == 2);
      cyc($sformatf("dirty_fill_%0d", i), i == 2 ? 15'b0_1_0_01_01_01_01_0_0_00 : FILL_O);
    end
    drive(1, 0, 2'b01, 2'b00, 0, 0);
    cyc("dirty_hit", HIT_RD);
    drive(1, 0, 2'b00, 2'b00, 0, 0);
    cyc("rst_idle", 15'b0);
    for (int i = 1; i <= 3; i++) begin
      rst = (i == 3);
      cyc($sformatf("rst_fill_%0d", i), FILL_O);
    end
    rst = 1'b0;
    drive(0, 0, 2'b00, 2'b00, 0, 0);
    cyc("rst_after", 15'b0);
    cyc("rst_after2", 15'b0);
    for (int i = 0; i < 8; i++) begin
      mcnt[i] = 0; dlru[i] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        dtag[i][k] = 2'b00; dvalid[i][k] = 1'b0; ddirty[i][k] = 1'b0;
        mtag[i][k] = 0; mdirty[i][k] = 1'b0;
      end
    end
    pc = 0; plat = $urandom_range(1, 4);
    for (int r = 0; r < 150; r++) begin
      s = $urandom_range(0, 1); t = $urandom_range(0, 3); w = $urandom_range(0, 1);
      pos = -1;
      for (int k = 0; k < mcnt[s]; k++) if (mtag[s][k] == t) pos = k;
      exp_hit = pos >= 0;
      exp_wb = !exp_hit && mcnt[s] == 2 && mdirty[s][1];
      vw = -1;
      if (mcnt[s] == 2)
        for (int k = 0; k < 2; k++) if (dvalid[s][k] && int'(dtag[s][k]) == mtag[s][1]) vw = k;
      mem_write = w[0]; mem_read = w[0] ? 1'($urandom_range(0, 1)) : 1'b1;
      c = 0; lat = -1; wbc = 0; fc = 0; badsel = 0; both = 0; done = 1'b0;
      while (!done && c < 40) begin
        hit = {dvalid[s][1] && dtag[s][1] == t[1:0], dvalid[s][0] && dtag[s][0] == t[1:0]};
        dirty = {ddirty[s][1], ddirty[s][0]};
        lru = dlru[s];
        pmem_resp = 1'b0;
        #1;
        if (pmem_read || pmem_write) begin pc++; pmem_resp = (pc == plat); end
        if (pmem_read && pmem_write) both++;
        if (pmem_write) begin wbc++; if (int'(address_to_pmem_sel) != 1 + vw) badsel++; end
        if (pmem_read) fc++;
        #1;
        if (mem_resp) begin done = 1'b1; lat = c; end
        for (int k = 0; k < 2; k++) begin
          if (tag_write[k]) dtag[s][k] = t[1:0];
          if (valid_write[k]) dvalid[s][k] = 1'b1;
          if (dirty_write[k]) ddirty[s][k] = mem_write;
        end
        if (lru_write) dlru[s] = hit[0];
        if (pmem_resp) begin pc = 0; plat = $urandom_range(1, 4); end
        c++;
        @(negedge clk);
      end
      chk("rand_resp", int'(done), 1);
      chk("rand_wb", int'(wbc > 0), int'(exp_wb));
      chk("rand_fill", int'(fc > 0), int'(!exp_hit));
      chk("rand_lat", lat, exp_hit ? 0 : 1 + wbc + fc);
      chk("rand_wbsel", badsel, 0);
      chk("rand_excl", both, 0);
      if (exp_hit) begin
        if (pos == 1) begin
          mtag[s][1] = mtag[s][0]; mtag[s][0] = t;
          {mdirty[s][0], mdirty[s][1]} = {mdirty[s][1], mdirty[s][0]};
        end
        mdirty[s][0] = mdirty[s][0] | w[0];
      end else begin
        mtag[s][1] = mtag[s][0]; mdirty[s][1] = mdirty[s][0];
        mtag[s][0] = t; mdirty[s][0] = w[0];
        mcnt[s] = mcnt[s] == 2 ? 2 : mcnt[s] + 1;
      end
      if ($urandom_range(0, 3) == 0) begin
        drive(0, 0, 2'b00, 2'b00, 0, 0);
        cyc("rand_idle", 15'b0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
